// File: rtl/control_sequencer_pkg.sv
// Shared constants for the SAP-style control sequencer: opcodes, control-word
// bit positions, ring-state encodings and the per-state control words.
package control_sequencer_pkg;

  localparam int CTRL_W = 12;
  localparam int RING_W = 6;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control-word bit positions, MSB first: {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
  localparam int CTRL_CP   = 11;
  localparam int CTRL_EP   = 10;
  localparam int CTRL_LM_N = 9;
  localparam int CTRL_CE_N = 8;
  localparam int CTRL_LI_N = 7;
  localparam int CTRL_EI_N = 6;
  localparam int CTRL_LA_N = 5;
  localparam int CTRL_EA   = 4;
  localparam int CTRL_SU   = 3;
  localparam int CTRL_EU   = 2;
  localparam int CTRL_LB_N = 1;
  localparam int CTRL_LO_N = 0;

  localparam logic [RING_W-1:0] T1_OH = 6'b000001;
  localparam logic [RING_W-1:0] T2_OH = 6'b000010;
  localparam logic [RING_W-1:0] T3_OH = 6'b000100;
  localparam logic [RING_W-1:0] T4_OH = 6'b001000;
  localparam logic [RING_W-1:0] T5_OH = 6'b010000;
  localparam logic [RING_W-1:0] T6_OH = 6'b100000;

  localparam logic [CTRL_W-1:0] CW_IDLE   = 12'h3E3;
  localparam logic [CTRL_W-1:0] CW_T1     = 12'h5E3;
  localparam logic [CTRL_W-1:0] CW_T2     = 12'hBE3;
  localparam logic [CTRL_W-1:0] CW_T3     = 12'h263;
  localparam logic [CTRL_W-1:0] CW_MEM_T4 = 12'h1A3;
  localparam logic [CTRL_W-1:0] CW_LDA_T5 = 12'h2C3;
  localparam logic [CTRL_W-1:0] CW_ALU_T5 = 12'h2E1;
  localparam logic [CTRL_W-1:0] CW_ADD_T6 = 12'h3C7;
  localparam logic [CTRL_W-1:0] CW_SUB_T6 = 12'h3CF;
  localparam logic [CTRL_W-1:0] CW_OUT_T4 = 12'h3F2;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot timing ring with freeze input; any non-one-hot value
// recovers to T1 on the next edge.
//   state | meaning
//   T1    | address fetch (PC -> MAR)
//   T2    | increment PC
//   T3    | memory -> IR
//   T4-T6 | execute, opcode-dependent
module ring_counter
  import control_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              hold,
  output logic [RING_W-1:0] t_state
);

  logic [RING_W-1:0] ring_q;
  logic [RING_W-1:0] ring_d;

  always_comb begin
    ring_d = ring_q;
    if (!$onehot(ring_q)) begin
      ring_d = T1_OH;
    end else if (!hold) begin
      ring_d = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ring_q <= T1_OH;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign t_state = ring_q;

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: combinational control-word decode from ring state and
// opcode, plus the sticky halt flag that freezes the ring at T4.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RING_W-1:0] t_state,
  output logic              hlt
);

  logic halt_q;
  logic halt_d;
  logic hlt_in_t4;
  logic hold;

  ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .hold    (hold),
    .t_state (t_state)
  );

  assign hlt_in_t4 = (t_state == T4_OH) && (opcode == OP_HLT);
  // Freezing on the same edge that sets the flag keeps the ring parked at T4.
  assign hold      = halt_q | hlt_in_t4;
  assign halt_d    = halt_q | hlt_in_t4;

  always_ff @(posedge clk) begin
    if (clr) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  always_comb begin
    ctrl = CW_IDLE;
    hlt  = 1'b0;
    if (clr) begin
      ctrl = CW_IDLE;
    end else if (halt_q) begin
      hlt = 1'b1;
    end else begin
      unique case (t_state)
        T1_OH: ctrl = CW_T1;
        T2_OH: ctrl = CW_T2;
        T3_OH: ctrl = CW_T3;
        T4_OH: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: ctrl = CW_MEM_T4;
            OP_OUT:                 ctrl = CW_OUT_T4;
            OP_HLT:                 hlt  = 1'b1;
            default:                ctrl = CW_IDLE;
          endcase
        end
        T5_OH: begin
          case (opcode)
            OP_LDA:         ctrl = CW_LDA_T5;
            OP_ADD, OP_SUB: ctrl = CW_ALU_T5;
            default:        ctrl = CW_IDLE;
          endcase
        end
        T6_OH: begin
          case (opcode)
            OP_ADD:  ctrl = CW_ADD_T6;
            OP_SUB:  ctrl = CW_SUB_T6;
            default: ctrl = CW_IDLE;
          endcase
        end
        default: ctrl = CW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic [11:0] ctrl;
  logic [5:0]  t_state;
  logic        hlt;

  typedef struct {
    string       tag;
    logic [11:0] ctrl;
    logic [5:0]  t_state;
    logic        hlt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  control_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .opcode  (opcode),
    .ctrl    (ctrl),
    .t_state (t_state),
    .hlt     (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, "_ctrl"}, {4'h0, ctrl},      {4'h0, e.ctrl});
      chk({e.tag, "_tst"},  {10'h0, t_state},  {10'h0, e.t_state});
      chk({e.tag, "_hlt"},  {15'h0, hlt},      {15'h0, e.hlt});
    end
  end

  // Drive one cycle's inputs just after the edge and queue what that cycle must show.
  task automatic cyc(input logic c, input logic [3:0] op, input logic [11:0] ec,
                     input logic [5:0] et, input logic eh, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    clr    = c;
    opcode = op;
    e.tag = tag; e.ctrl = ec; e.t_state = et; e.hlt = eh;
    sb_q.push_back(e);
  endtask

  function automatic logic [3:0] rand_op();
    return 4'($urandom_range(0, 15));
  endfunction

  // T1..T3 use random opcodes: fetch must not depend on them.
  task automatic run_fetch(input string tag);
    cyc(1'b0, rand_op(), 12'h5E3, 6'b000001, 1'b0, {tag, "_t1"});
    cyc(1'b0, rand_op(), 12'hBE3, 6'b000010, 1'b0, {tag, "_t2"});
    cyc(1'b0, rand_op(), 12'h263, 6'b000100, 1'b0, {tag, "_t3"});
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [11:0] w4,
                           input logic [11:0] w5, input logic [11:0] w6, input string tag);
    run_fetch(tag);
    cyc(1'b0, op, w4, 6'b001000, 1'b0, {tag, "_t4"});
    cyc(1'b0, op, w5, 6'b010000, 1'b0, {tag, "_t5"});
    cyc(1'b0, op, w6, 6'b100000, 1'b0, {tag, "_t6"});
  endtask

  initial begin
    clr    = 1'b1;
    opcode = 4'b0000;

    cyc(1'b1, 4'b0000, 12'h3E3, 6'b000001, 1'b0, "rst0");
    cyc(1'b1, 4'b1111, 12'h3E3, 6'b000001, 1'b0, "rst1");

    run_instr(4'b0000, 12'h1A3, 12'h2C3, 12'h3E3, "lda");
    run_instr(4'b0001, 12'h1A3, 12'h2E1, 12'h3C7, "add");
    run_instr(4'b0010, 12'h1A3, 12'h2E1, 12'h3CF, "sub");
    run_instr(4'b1110, 12'h3F2, 12'h3E3, 12'h3E3, "out");
    run_instr(4'b0101, 12'h3E3, 12'h3E3, 12'h3E3, "nop5");
    run_instr(4'b1000, 12'h3E3, 12'h3E3, 12'h3E3, "nop8");
    run_instr(4'b0000, 12'h1A3, 12'h2C3, 12'h3E3, "lda2");

    run_fetch("hltf");
    cyc(1'b0, 4'b1111, 12'h3E3, 6'b001000, 1'b1, "hlt_t4");
    cyc(1'b0, 4'b0000, 12'h3E3, 6'b001000, 1'b1, "hold1");
    cyc(1'b0, 4'b1110, 12'h3E3, 6'b001000, 1'b1, "hold2");
    cyc(1'b0, 4'b0001, 12'h3E3, 6'b001000, 1'b1, "hold3");
    cyc(1'b0, 4'b0010, 12'h3E3, 6'b001000, 1'b1, "hold4");
    cyc(1'b0, 4'b1111, 12'h3E3, 6'b001000, 1'b1, "hold5");
    cyc(1'b1, 4'b0000, 12'h3E3, 6'b001000, 1'b0, "hlt_clr");
    run_instr(4'b0001, 12'h1A3, 12'h2E1, 12'h3C7, "add_ah");

    run_fetch("midf");
    cyc(1'b0, 4'b0001, 12'h1A3, 6'b001000, 1'b0, "mid_t4");
    cyc(1'b1, 4'b0001, 12'h3E3, 6'b010000, 1'b0, "mid_clr");
    run_instr(4'b0010, 12'h1A3, 12'h2E1, 12'h3CF, "sub_am");

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 16'(sb_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The first port SHALL be `clk`, input, 1 bit: the system clock; all state SHALL update on its rising edge only.
REQ-003 The second port SHALL be `clr`, input, 1 bit: the synchronous, active-high reset.
REQ-004 Port `opcode`, input, 4 bits: upper nibble of the instruction register output; valid from T4 onward.
REQ-005 Port `ctrl`, output, 12 bits: control word {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}, bit 11 = Cp; *_n bits are active-low.
REQ-006 Port `t_state`, output, 6 bits: one-hot ring state; bit 0 = T1, bit 5 = T6.
REQ-007 Port `hlt`, output, 1 bit: high while the machine is halted.

Function
REQ-008 The ring SHALL advance T1→T2→…→T6→T1, one state per rising edge, when not halted and `clr`=0.
REQ-009 `ctrl` SHALL be a combinational decode of `t_state`, `opcode` and the halt flag; state is registered.
REQ-010 The idle control word SHALL be 12'h3E3 (all strobes inactive).
REQ-011 Fetch values, independent of `opcode`: T1=12'h5E3 (Ep, Lm_n); T2=12'hBE3 (Cp); T3=12'h263 (CE_n, Li_n).
REQ-012 LDA (0000) SHALL drive T4=12'h1A3, T5=12'h2C3, T6=12'h3E3.
REQ-013 ADD (0001) SHALL drive T4=12'h1A3, T5=12'h2E1, T6=12'h3C7.
REQ-014 SUB (0010) SHALL drive T4=12'h1A3, T5=12'h2E1, T6=12'h3CF.
REQ-015 OUT (1110) SHALL drive T4=12'h3F2, T5=12'h3E3, T6=12'h3E3.
REQ-016 Any other opcode except 1111 SHALL be a NOP: T4–T6 = 12'h3E3, and the ring continues.
REQ-017 HLT (1111) in T4: `ctrl` SHALL be 12'h3E3 and `hlt` SHALL be 1 combinationally.
REQ-018 HLT (1111) in T4: on the next edge the halt flag SHALL set and the ring SHALL freeze at T4.
REQ-019 While halted, `ctrl` SHALL stay 12'h3E3, `hlt` SHALL stay 1, and `opcode` changes SHALL be ignored.
REQ-020 Only `clr` SHALL release the halt state.
REQ-021 `opcode` SHALL be ignored during T1–T3.
REQ-022 The `t_state` encoding SHALL always be one-hot; an illegal encoding SHALL return to T1 on the next edge.

Reset
REQ-023 When `clr`=1 at a rising edge, `t_state` SHALL become 6'b000001 and the halt flag SHALL clear.
REQ-024 While `clr`=1, `ctrl` SHALL be forced to 12'h3E3 and `hlt` to 0, regardless of state.
REQ-025 `clr` SHALL take priority over halt and over ring advance in any T-state, including mid-instruction.
REQ-026 On the first edge after `clr` deasserts, the ring SHALL move T1→T2; the T1 word SHALL be visible in the cycle between.

Structure
REQ-027 A shared package SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the ctrl bit indices, the idle word and the per-state control-word constants.
REQ-028 One sub-module `ring_counter` SHALL implement the 6-bit one-hot ring with `clk`, `clr` and `hold` (freeze) inputs.
REQ-029 Decode and halt logic SHALL live in `control_sequencer`.

Verification
REQ-030 Reset: `clr`=1 for 2 edges → `t_state`=000001, `ctrl`=3E3, `hlt`=0.
REQ-031 Release from reset: `clr`→0 → T1 `ctrl`=5E3.
REQ-032 LDA: `opcode`=0000 → 5E3, BE3, 263, 1A3, 2C3, 3E3 over 6 cycles, then T1 again.
REQ-033 ADD then SUB: back-to-back, `opcode`=0001 then 0010 → T6 words 3C7 then 3CF; T4/T5 = 1A3/2E1 for both.
REQ-034 OUT, then NOP 0101: → OUT T4=3F2; NOP T4–T6 = 3E3; ring does not stall.
REQ-035 HLT: `opcode`=1111 at T4 → `hlt`=1, `t_state` held at 001000 for 5 edges with `opcode` toggling; `clr` pulse → T1, `hlt`=0.
REQ-036 Mid-instruction reset: `clr`=1 during ADD T5 → `ctrl`=3E3 immediately; next edge `t_state`=000001.
